nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL provide parameter APR, default 32, phase-increment width.
REQ-002 SHALL provide parameter DWW, default 16, dwell-counter width.
REQ-003 SHALL provide parameter LAT, default 10, NCO clken-to-output latency in enabled cycles.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  config write strobe.
REQ-007 cfg_addr  input  2  register select: 0 start_inc, 1 stop_inc, 2 step_inc, 3 dwell.
REQ-008 cfg_data  input  APR  write data; dwell uses bits [DWW-1:0].
REQ-009 start  input  1  one-cycle sweep start pulse.
REQ-010 abort  input  1  one-cycle sweep abort pulse.
REQ-011 phi_inc_o  output  APR  phase increment driven to the NCO.
REQ-012 nco_clken  output  1  NCO clock enable.
REQ-013 busy  output  1  high from the cycle after an accepted start until the cycle done pulses or the abort is taken.
REQ-014 done  output  1  one-cycle pulse on normal sweep completion.
REQ-015 seg_mark  output  1  pulse marking first NCO output sample of each new frequency step.

Function
REQ-016 FSM states: IDLE, DWELL, FLUSH; all outputs registered.
REQ-017 cfg_we in IDLE writes the addressed register next edge; cfg_we while busy is ignored.
REQ-018 IDLE: nco_clken=0, phi_inc_o holds its last value.
REQ-019 start in IDLE: next cycle phi_inc_o=start_inc, dwell_cnt=max(dwell,1)-1, state DWELL, busy=1, nco_clken=1; start while busy is ignored.
REQ-020 DWELL: nco_clken=1; dwell_cnt decrements each cycle; each frequency is held exactly max(dwell,1) cycles.
REQ-021 At dwell_cnt==0: next=phi_inc_o+step_inc computed in APR+1 bits, unsigned.
REQ-022 If step_inc==0, or carry out, or next>stop_inc: go to FLUSH with flush_cnt=LAT-1, phi_inc_o held.
REQ-023 Otherwise: phi_inc_o<=next[APR-1:0], dwell_cnt reloaded, stay in DWELL; next==stop_inc is a valid final step.
REQ-024 start_inc>stop_inc: exactly one dwell at start_inc, then FLUSH.
REQ-025 FLUSH: nco_clken=1 for LAT cycles; on flush_cnt==0 pulse done for 1 cycle, busy=0 and IDLE in the same cycle.
REQ-026 seg_mark: a load event fires each cycle phi_inc_o takes a new value (start load and each step); delayed through a LAT-stage shift register advanced only when nco_clken=1; seg_mark is its output.
REQ-027 abort in any non-IDLE state: next cycle IDLE, busy=0, nco_clken=0, no done, seg_mark shift register cleared.
REQ-028 abort and start in the same cycle: abort wins, no sweep starts.
REQ-029 abort in IDLE: no effect.
REQ-030 Config registers keep values across sweeps and aborts.

Reset
REQ-031 reset_n low asynchronously forces: state IDLE, phi_inc_o=0, nco_clken=0, busy=0, done=0, seg_mark=0, shift register 0, start_inc=stop_inc=step_inc=0, dwell=1.
REQ-032 Reset deassertion mid-sweep: block resumes in IDLE; first start after reset is honoured.

Verification
REQ-033 start=100, stop=300, step=100, dwell=4, start -> phi_inc_o 100,200,300 for 4 cycles each; nco_clken high 12+LAT cycles; done one cycle after; busy 12+LAT cycles total.
REQ-034 Same config, LAT=10 -> seg_mark pulses 10 cycles after each phi_inc_o change (3 pulses).
REQ-035 start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x200, dwell=2 -> single step at 0xFFFFFF00, carry ends sweep, done after 2+LAT cycles.
REQ-036 step=0 or dwell=0, start -> one dwell of 1 cycle (dwell=0) or dwell cycles (step=0), then FLUSH and done.
REQ-037 abort 3 cycles into DWELL, and abort with simultaneous start in IDLE -> IDLE next cycle, no done, no further seg_mark; cfg_we during busy leaves registers unchanged.
REQ-038 reset_n pulsed low mid-DWELL -> all outputs 0 immediately; config registers reset to REQ-031 values.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - stepped-frequency sweep controller driving an NCO phase increment
module nco_sweep_ctrl #(
    parameter int APR = 32,
    parameter int DWW = 16,
    parameter int LAT = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_addr,
    input  logic [APR-1:0] cfg_data,
    input  logic           start,
    input  logic           abort,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken,
    output logic           busy,
    output logic           done,
    output logic           seg_mark
);

    localparam int FCW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [APR-1:0] start_inc, stop_inc, step_inc;
    logic [DWW-1:0] dwell;
    logic [DWW-1:0] dwell_cnt, dwell_cnt_nxt, dwell_reload;
    logic [FCW-1:0] flush_cnt, flush_cnt_nxt;
    logic [APR-1:0] phi_nxt;
    logic           clken_nxt, busy_nxt, done_nxt;
    logic           load_evt, load_nxt;
    logic [LAT-1:0] seg_sr, seg_sr_nxt;
    logic [APR:0]   step_sum;
    logic           step_end;

    assign dwell_reload = (dwell == '0) ? '0 : dwell - DWW'(1);
    assign step_sum     = {1'b0, phi_inc_o} + {1'b0, step_inc};
    // A carry shows up as step_sum[APR], which already exceeds any stop value.
    assign step_end     = (step_inc == '0) || (step_sum > {1'b0, stop_inc});
    assign seg_mark     = seg_sr[LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_inc <= '0;
            stop_inc  <= '0;
            step_inc  <= '0;
            dwell     <= DWW'(1);
        end else if (cfg_we && state == IDLE) begin
            case (cfg_addr)
                2'd0:    start_inc <= cfg_data;
                2'd1:    stop_inc  <= cfg_data;
                2'd2:    step_inc  <= cfg_data;
                default: dwell     <= cfg_data[DWW-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            flush_cnt <= '0;
            phi_inc_o <= '0;
            nco_clken <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_evt  <= 1'b0;
            seg_sr    <= '0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            phi_inc_o <= phi_nxt;
            nco_clken <= clken_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            load_evt  <= load_nxt;
            seg_sr    <= seg_sr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dwell_cnt_nxt = dwell_cnt;
        flush_cnt_nxt = flush_cnt;
        phi_nxt       = phi_inc_o;
        clken_nxt     = nco_clken;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        load_nxt      = 1'b0;
        case (state)
            IDLE: begin
                clken_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (start && !abort) begin
                    state_nxt     = DWELL;
                    phi_nxt       = start_inc;
                    dwell_cnt_nxt = dwell_reload;
                    clken_nxt     = 1'b1;
                    busy_nxt      = 1'b1;
                    load_nxt      = 1'b1;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_nxt = IDLE;
                    clken_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (dwell_cnt != '0) begin
                    dwell_cnt_nxt = dwell_cnt - DWW'(1);
                end else if (step_end) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FCW'(LAT - 1);
                end else begin
                    phi_nxt       = step_sum[APR-1:0];
                    dwell_cnt_nxt = dwell_reload;
                    load_nxt      = 1'b1;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_nxt = IDLE;
                    clken_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (flush_cnt == '0) begin
                    state_nxt = IDLE;
                    clken_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    flush_cnt_nxt = flush_cnt - FCW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                clken_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Load markers travel with the NCO pipeline, so they only move on enabled cycles.
    always_comb begin
        seg_sr_nxt = seg_sr;
        if (abort && state != IDLE) begin
            seg_sr_nxt = '0;
        end else if (nco_clken) begin
            seg_sr_nxt = LAT'({seg_sr, load_evt});
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start;
    logic        abort;
    logic [31:0] phi_inc_o;
    logic        nco_clken;
    logic        busy;
    logic        done;
    logic        seg_mark;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] st;
        logic [15:0] dw;
        int          exp_steps;
        int          exp_busy;
        logic [31:0] exp_final;
    } vec_t;

    vec_t tbl[7];

    nco_sweep_ctrl #(.APR(32), .DWW(16), .LAT(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .abort     (abort),
        .phi_inc_o (phi_inc_o),
        .nco_clken (nco_clken),
        .busy      (busy),
        .done      (done),
        .seg_mark  (seg_mark)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] obs();
        return {phi_inc_o, nco_clken, busy, done, seg_mark};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic program_cfg(input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] st, input logic [15:0] dw);
        write_reg(2'd0, s);
        write_reg(2'd1, e);
        write_reg(2'd2, st);
        write_reg(2'd3, {16'h0, dw});
    endtask

    // Expected timeline built from the frequency list: nf*D dwell cycles, LAT flush cycles, done.
    task automatic sweep_check(input string tag, input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] st, input logic [15:0] dw,
                               output int n_seg, output int n_busy, output logic [31:0] fin);
        logic [31:0]       freqs[$];
        longint unsigned   f;
        int                d, nf, t, k;
        logic [31:0]       ephi;
        logic              eclk, ebusy, edone, eseg;
        freqs.delete();
        f = longint'(s);
        freqs.push_back(s);
        while (st != 0 && f + longint'(st) <= longint'(e)) begin
            f = f + longint'(st);
            freqs.push_back(f[31:0]);
        end
        d  = (dw == 0) ? 1 : int'(dw);
        nf = freqs.size();
        t  = nf * d + LAT + 1;
        n_seg  = 0;
        n_busy = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= t + 1; i++) begin
            @(negedge clk);
            if (i <= nf * d) begin
                k = (i - 1) / d;
                ephi = freqs[k];
            end else begin
                ephi = freqs[nf - 1];
            end
            eclk  = (i < t);
            ebusy = (i < t);
            edone = (i == t);
            eseg  = (i > LAT) && (((i - 1 - LAT) % d) == 0) && (((i - 1 - LAT) / d) < nf);
            check($sformatf("%s cyc%0d", tag, i), 64'(obs()), 64'({ephi, eclk, ebusy, edone, eseg}));
            if (seg_mark) n_seg++;
            if (busy) n_busy++;
        end
        fin = phi_inc_o;
    endtask

    initial begin
        int          n_seg, n_busy;
        logic [31:0] fin;
        logic [31:0] rs, re, rst_v;
        logic [15:0] rdw;

        tbl[0] = '{32'd100, 32'd300, 32'd100, 16'd4, 3, 4 * 3 + LAT, 32'd300};
        tbl[1] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd2, 1, 2 + LAT, 32'hFFFF_FF00};
        tbl[2] = '{32'd50, 32'd500, 32'd0, 16'd3, 1, 3 + LAT, 32'd50};
        tbl[3] = '{32'd7, 32'd7, 32'd5, 16'd0, 1, 1 + LAT, 32'd7};
        tbl[4] = '{32'd500, 32'd100, 32'd10, 16'd2, 1, 2 + LAT, 32'd500};
        tbl[5] = '{32'd10, 32'd40, 32'd10, 16'd1, 4, 4 + LAT, 32'd40};
        tbl[6] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 16'd1, 2, 2 + LAT, 32'h8000_0000};

        reset_n  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 32'd0;
        start    = 1'b0;
        abort    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'(obs()), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle after reset", 64'(obs()), 64'd0);

        sweep_check("default cfg", 32'd0, 32'd0, 32'd0, 16'd1, n_seg, n_busy, fin);

        for (int v = 0; v < 7; v++) begin
            program_cfg(tbl[v].s, tbl[v].e, tbl[v].st, tbl[v].dw);
            sweep_check($sformatf("tbl%0d", v), tbl[v].s, tbl[v].e, tbl[v].st, tbl[v].dw,
                        n_seg, n_busy, fin);
            check($sformatf("tbl%0d seg count", v), 64'(n_seg), 64'(tbl[v].exp_steps));
            check($sformatf("tbl%0d busy cycles", v), 64'(n_busy), 64'(tbl[v].exp_busy));
            check($sformatf("tbl%0d final phi", v), 64'(fin), 64'(tbl[v].exp_final));
        end

        // Abort three cycles into a dwell, with a config write attempted while busy.
        program_cfg(32'd100, 32'd300, 32'd100, 16'd4);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        write_reg(2'd0, 32'd999);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort idle", 64'(obs()), 64'({32'd100, 4'b0000}));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("post abort quiet%0d", i), 64'(obs() & 36'hF), 64'd0);
        end
        sweep_check("after abort", 32'd100, 32'd300, 32'd100, 16'd4, n_seg, n_busy, fin);
        check("after abort seg count", 64'(n_seg), 64'd3);

        // Abort and start together in IDLE: no sweep.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("abort+start idle%0d", i), 64'(obs()), 64'({32'd300, 4'b0000}));
        end

        // Asynchronous reset in the middle of a dwell.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset outputs", 64'(obs()), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sweep_check("post reset cfg", 32'd0, 32'd0, 32'd0, 16'd1, n_seg, n_busy, fin);
        check("post reset busy cycles", 64'(n_busy), 64'(1 + LAT));

        for (int it = 0; it < 25; it++) begin
            if (it % 4 == 3) begin
                rs    = 32'hFFFF_F000 | $urandom_range(0, 4095);
                re    = 32'hFFFF_FF00 | $urandom_range(0, 255);
                rst_v = $urandom_range(100, 1000);
            end else begin
                rs    = $urandom_range(0, 2000);
                re    = $urandom_range(0, 3000);
                rst_v = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(40, 400));
            end
            rdw = 16'($urandom_range(0, 4));
            program_cfg(rs, re, rst_v, rdw);
            sweep_check($sformatf("rand%0d", it), rs, re, rst_v, rdw, n_seg, n_busy, fin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
